fetch_unit: RTL and testbench

- Instruction fetch stage feeding the core's decode stage.
- Generates the program counter and drives a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a 2-entry prefetch queue and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush queued and in-flight fetches.

---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_queue.sv | 51 +++++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Core-wide fetch defaults and the queue entry layout shared by the fetch stage.
package fetch_unit_pkg;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_RESET_PC = 0;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {instr, pc} words between imem and decode.
module fetch_queue #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) rd_ptr <= !rd_ptr;
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The issue rule upstream guarantees a free slot for every returning response.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && !flush && count == 2'd2))
    else $error("fetch_queue overflow");
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, 1-cycle imem request/response tracking, and the prefetch queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_ext,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  pending_pc;
  logic               inflight;
  logic [1:0]         count;
  logic [2:0]         occupancy;
  logic               pop;
  logic               push;
  logic               issue;
  logic [ENTRY_W-1:0] head;

  // Decode handshake: an entry transfers on any cycle where out_valid && out_ready
  // at the rising edge; while out_valid=1 and out_ready=0 the head is held unchanged.
  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = !rst_ext && !redirect && (occupancy < 3'd2);
  // A response landing in a redirect cycle belongs to the discarded path.
  assign push      = inflight && !redirect;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head[ENTRY_W-1:ADDR_W];
  assign out_pc    = head[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      fetch_pc   <= RESET_PC;
      pending_pc <= RESET_PC;
      inflight   <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc   <= fetch_pc + ADDR_W'(1);
        pending_pc <= fetch_pc;
      end
    end
  end

  fetch_queue #(.W(ENTRY_W)) u_queue (
    .clk   (clk),
    .rst   (rst_ext),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({imem_rdata, pending_pc}),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboarded decode stream, latency, backpressure, redirect, wrap and reset cases.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int EW = $bits(fetch_entry_t);

  logic        clk = 1'b0;
  logic        rst_ext;
  logic        imem_req, imem_req_w;
  logic [7:0]  imem_addr, imem_addr_w;
  logic [15:0] imem_rdata = '0;
  logic [15:0] imem_rdata_w = '0;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        out_valid, out_valid_w;
  logic        out_ready;
  logic [15:0] out_instr, out_instr_w;
  logic [7:0]  out_pc, out_pc_w;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    last_pc = '0;
  logic [7:0]    p_exp;
  int            wrap_seen = 0;
  logic [7:0]    wrap_pcs [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_ext(rst_ext), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_unit #(.RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .rst_ext(rst_ext), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .redirect(1'b0), .redirect_pc(8'h00),
    .out_valid(out_valid_w), .out_ready(1'b1), .out_instr(out_instr_w), .out_pc(out_pc_w)
  );

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'hC3, a};
  endfunction

  // Synchronous instruction memories; junk on idle cycles exposes stale captures.
  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? mem_word(imem_addr)   : 16'($urandom);
    imem_rdata_w <= imem_req_w ? mem_word(imem_addr_w) : 16'($urandom);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] start, input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 8'(i);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (out_valid && out_ready) begin
      check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("out_entry", 32'({out_instr, out_pc}), 32'(e));
      end
      last_pc <= out_pc;
    end
    if (out_valid_w && wrap_seen < 4) begin
      check_val("wrap_entry", 32'({out_instr_w, out_pc_w}),
                32'({mem_word(wrap_pcs[wrap_seen]), wrap_pcs[wrap_seen]}));
      wrap_seen++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_ext = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    repeat (3) tick();
    check_val("rst_req", 32'(imem_req), 32'd0);
    check_val("rst_addr", 32'(imem_addr), 32'h00);
    check_val("rst_addr_wrap", 32'(imem_addr_w), 32'hFE);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_instr", 32'(out_instr), 32'd0);
    check_val("rst_pc", 32'(out_pc), 32'd0);

    // Free run from reset
    push_exp(8'h00, 64);
    out_ready = 1'b1;
    rst_ext = 1'b0;
    tick();
    check_val("start_lat1", 32'(out_valid), 32'd0);
    tick();
    check_val("start_lat2", 32'(out_valid), 32'd1);
    check_val("start_pc", 32'(out_pc), 32'h00);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("no_gap", 32'(out_valid), 32'd1);
    end

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_valid", 32'(out_valid), 32'd1);
      check_val("bp_hold", 32'({out_instr, out_pc}), 32'(exp_q[0]));
    end
    check_val("bp_req_off", 32'(imem_req), 32'd0);
    out_ready = 1'b1;
    repeat (6) tick();

    // Redirect with a full queue: head accepted, second entry dropped
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
    p_exp = exp_q[0][7:0];
    tick();
    check_val("redir_flush", 32'(out_valid), 32'd0);
    check_val("redir_addr", 32'(imem_addr), 32'h40);
    check_val("redir_head_taken", 32'(last_pc), 32'(p_exp));
    redirect = 1'b0;
    exp_q.delete();
    push_exp(8'h40, 16);
    @(negedge clk);
    check_val("redir_req", 32'(imem_req), 32'd1);
    tick();
    check_val("redir_lat1", 32'(out_valid), 32'd0);
    tick();
    check_val("redir_lat2", 32'(out_valid), 32'd1);
    check_val("redir_pc", 32'(out_pc), 32'h40);
    repeat (4) tick();

    // Back-to-back redirects from steady state (response in flight)
    p_exp = exp_q[0][7:0];
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    check_val("b2b_head_taken", 32'(last_pc), 32'(p_exp));
    exp_q.delete();
    redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    push_exp(8'h20, 64);
    check_val("b2b_flush", 32'(out_valid), 32'd0);
    tick();
    check_val("b2b_lat1", 32'(out_valid), 32'd0);
    tick();
    check_val("b2b_lat2", 32'(out_valid), 32'd1);
    check_val("b2b_pc", 32'(out_pc), 32'h20);

    // Random decode stalls
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Asynchronous reset between edges with the queue full
    out_ready = 1'b0;
    repeat (3) tick();
    #2 rst_ext = 1'b1;
    #1;
    check_val("arst_valid", 32'(out_valid), 32'd0);
    check_val("arst_req", 32'(imem_req), 32'd0);
    check_val("arst_pc", 32'(out_pc), 32'd0);
    exp_q.delete();
    push_exp(8'h00, 32);
    repeat (2) tick();
    rst_ext = 1'b0; out_ready = 1'b1;
    tick();
    check_val("arst_lat1", 32'(out_valid), 32'd0);
    tick();
    check_val("arst_lat2", 32'(out_valid), 32'd1);
    check_val("arst_pc0", 32'(out_pc), 32'h00);
    repeat (6) tick();

    out_ready = 1'b0;
    tick();
    check_val("wrap_count", 32'(wrap_seen), 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
